// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared widths, ALU opcodes, forward-select encoding and the ID/EX register layout.
package rv_pipe_pkg;
    localparam int XLEN    = 32;
    localparam int OPW     = 3;
    localparam int REGADDR = 5;
    localparam logic [OPW-1:0] ALU_ADD = 3'd0;
    localparam logic [OPW-1:0] ALU_SUB = 3'd1;
    localparam logic [OPW-1:0] ALU_AND = 3'd2;
    localparam logic [OPW-1:0] ALU_OR  = 3'd3;
    localparam logic [OPW-1:0] ALU_XOR = 3'd4;
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXM = 2'd1;
    localparam logic [1:0] FWD_MWB = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [REGADDR-1:0] rs1;
        logic [REGADDR-1:0] rs2;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic               use_imm;
        logic [OPW-1:0]     alu_op;
        logic [REGADDR-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } ex_reg_t;

    // EX/MEM is the younger result, so it outranks MEM/WB; x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [REGADDR-1:0] src,
        input logic [REGADDR-1:0] exm_rd,
        input logic               exm_we,
        input logic [REGADDR-1:0] mwb_rd,
        input logic               mwb_we
    );
        return (exm_we && exm_rd != '0 && exm_rd == src) ? FWD_EXM :
               (mwb_we && mwb_rd != '0 && mwb_rd == src) ? FWD_MWB : FWD_REG;
    endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the freshest value of one source register from EX/MEM, MEM/WB or the latched regfile read.
module fwd_mux
    import rv_pipe_pkg::*;
(
    input  logic [REGADDR-1:0] i_src,
    input  logic [XLEN-1:0]    i_data,
    input  logic [REGADDR-1:0] i_exm_rd,
    input  logic               i_exm_we,
    input  logic [XLEN-1:0]    i_exm_result,
    input  logic [REGADDR-1:0] i_mwb_rd,
    input  logic               i_mwb_we,
    input  logic [XLEN-1:0]    i_mwb_result,
    output logic [XLEN-1:0]    o_value
);
    logic [1:0] w_sel;

    assign w_sel   = fwd_sel(i_src, i_exm_rd, i_exm_we, i_mwb_rd, i_mwb_we);
    assign o_value = (i_src == '0)      ? '0 :
                     (w_sel == FWD_EXM) ? i_exm_result :
                     (w_sel == FWD_MWB) ? i_mwb_result : i_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and operand forwarding into the ALU.
module id_ex_stage
    import rv_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REGADDR-1:0] id_rs1,
    input  logic [REGADDR-1:0] id_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_use_imm,
    input  logic [OPW-1:0]     id_alu_op,
    input  logic [REGADDR-1:0] id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic [REGADDR-1:0] exm_rd,
    input  logic               exm_reg_write,
    input  logic [XLEN-1:0]    exm_result,
    input  logic [REGADDR-1:0] mwb_rd,
    input  logic               mwb_reg_write,
    input  logic [XLEN-1:0]    mwb_result,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [XLEN-1:0]    operand1,
    output logic [XLEN-1:0]    operand2,
    output logic [OPW-1:0]     alu_op,
    output logic [XLEN-1:0]    ex_rs2_fwd,
    output logic [REGADDR-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read
);
    ex_reg_t         r_ex;
    ex_reg_t         w_next;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign stall_id = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                      ((r_ex.rd == id_rs1) | ((r_ex.rd == id_rs2) & ~id_use_imm));

    always_comb begin
        w_next           = '0;
        w_next.valid     = id_valid;
        w_next.rs1       = id_rs1;
        w_next.rs2       = id_rs2;
        w_next.rs1_data  = id_rs1_data;
        w_next.rs2_data  = id_rs2_data;
        w_next.imm       = id_imm;
        w_next.use_imm   = id_use_imm;
        w_next.alu_op    = id_alu_op;
        w_next.rd        = id_rd;
        w_next.reg_write = id_reg_write & id_valid;
        w_next.mem_read  = id_mem_read & id_valid;
    end

    // flush and load-use both insert an all-zero bubble; decode re-presents on stall
    always_ff @(posedge clk)
        r_ex <= (rst || flush || stall_id) ? '0 : w_next;

    fwd_mux u_fwd_rs1 (
        .i_src(r_ex.rs1), .i_data(r_ex.rs1_data),
        .i_exm_rd(exm_rd), .i_exm_we(exm_reg_write), .i_exm_result(exm_result),
        .i_mwb_rd(mwb_rd), .i_mwb_we(mwb_reg_write), .i_mwb_result(mwb_result),
        .o_value(w_fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .i_src(r_ex.rs2), .i_data(r_ex.rs2_data),
        .i_exm_rd(exm_rd), .i_exm_we(exm_reg_write), .i_exm_result(exm_result),
        .i_mwb_rd(mwb_rd), .i_mwb_we(mwb_reg_write), .i_mwb_result(mwb_result),
        .o_value(w_fwd_rs2)
    );

    assign ex_valid     = r_ex.valid;
    assign operand1     = w_fwd_rs1;
    assign operand2     = r_ex.use_imm ? r_ex.imm : w_fwd_rs2;
    assign alu_op       = r_ex.alu_op;
    assign ex_rs2_fwd   = w_fwd_rs2;
    assign ex_rd        = r_ex.rd;
    assign ex_reg_write = r_ex.reg_write;
    assign ex_mem_read  = r_ex.mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of reset, forwarding, x0 guard, load-use stall, flush and immediate select.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_reg_write, id_mem_read;
    logic [2:0]  id_alu_op;
    logic        flush;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] operand1, operand2, ex_rs2_fwd;
    logic [2:0]  alu_op;
    logic [4:0]  ex_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
        .ex_rs2_fwd(ex_rs2_fwd), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic ui, input logic [2:0] op, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_alu_op = op; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clear_fwd();
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0;
        clear_fwd();
        set_id(1, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 0, 3'd3, 5'd9, 1, 1);
        step();
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", ex_valid); end
        checks++; if (alu_op !== 3'd0) begin errors++; $display("FAIL rst_alu_op got %0h exp 0", alu_op); end
        checks++; if (operand1 !== 32'd0 || operand2 !== 32'd0) begin errors++; $display("FAIL rst_operands got %0h/%0h exp 0/0", operand1, operand2); end
        checks++; if ({ex_rd, ex_reg_write, ex_mem_read} !== 7'd0) begin errors++; $display("FAIL rst_ctrl got %0h/%0h/%0h exp 0", ex_rd, ex_reg_write, ex_mem_read); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall_id); end
        rst = 0;
        set_id(1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 0, 3'd0, 5'd3, 1, 0);
        step();
        checks++; if (operand1 !== 32'd5) begin errors++; $display("FAIL add_op1 got %0h exp 5", operand1); end
        checks++; if (operand2 !== 32'd7) begin errors++; $display("FAIL add_op2 got %0h exp 7", operand2); end
        checks++; if (alu_op !== 3'd0 || ex_valid !== 1'b1) begin errors++; $display("FAIL add_ctrl got op %0h valid %0h exp 0/1", alu_op, ex_valid); end
        checks++; if (ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_rd got %0h/%0h exp 3/1", ex_rd, ex_reg_write); end
    endtask

    task automatic test_exm_fwd();
        set_id(1, 5'd4, 5'd2, 32'd1, 32'd3, 32'd0, 0, 3'd0, 5'd10, 1, 0);
        step();
        exm_rd = 5'd4; exm_reg_write = 1; exm_result = 32'h10;
        #1;
        checks++; if (operand1 !== 32'h10) begin errors++; $display("FAIL exm_fwd got %0h exp 10", operand1); end
        mwb_rd = 5'd4; mwb_reg_write = 1; mwb_result = 32'h20;
        #1;
        checks++; if (operand1 !== 32'h10) begin errors++; $display("FAIL exm_priority got %0h exp 10", operand1); end
        exm_reg_write = 0;
        #1;
        checks++; if (operand1 !== 32'h20) begin errors++; $display("FAIL mwb_fwd got %0h exp 20", operand1); end
        mwb_reg_write = 0;
        #1;
        checks++; if (operand1 !== 32'd1 || operand2 !== 32'd3) begin errors++; $display("FAIL reg_data got %0h/%0h exp 1/3", operand1, operand2); end
        clear_fwd();
    endtask

    task automatic test_x0_guard();
        set_id(1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 3'd2, 5'd11, 1, 0);
        step();
        exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'hFF;
        mwb_rd = 5'd0; mwb_reg_write = 1; mwb_result = 32'hEE;
        #1;
        checks++; if (operand1 !== 32'd0) begin errors++; $display("FAIL x0_op1 got %0h exp 0", operand1); end
        checks++; if (operand2 !== 32'd0) begin errors++; $display("FAIL x0_op2 got %0h exp 0", operand2); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        set_id(1, 5'd1, 5'd0, 32'd3, 32'd0, 32'd8, 1, 3'd0, 5'd5, 1, 1);
        step();
        checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL lw_capture got %0h/%0h exp 1/5", ex_mem_read, ex_rd); end
        set_id(1, 5'd5, 5'd1, 32'd0, 32'd3, 32'd0, 0, 3'd1, 5'd6, 1, 0);
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h exp 1", stall_id); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_op !== 3'd0) begin errors++; $display("FAIL lu_bubble got %0h/%0h/%0h exp 0/0/0", ex_valid, ex_reg_write, alu_op); end
        checks++; if (operand1 !== 32'd0 || operand2 !== 32'd0) begin errors++; $display("FAIL lu_bubble_ops got %0h/%0h exp 0/0", operand1, operand2); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %0h exp 0", stall_id); end
        step();
        mwb_rd = 5'd5; mwb_reg_write = 1; mwb_result = 32'h55;
        #1;
        checks++; if (operand1 !== 32'h55 || operand2 !== 32'd3) begin errors++; $display("FAIL lu_sub_ops got %0h/%0h exp 55/3", operand1, operand2); end
        checks++; if (alu_op !== 3'd1 || ex_rd !== 5'd6 || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_sub_ctrl got %0h/%0h/%0h exp 1/6/1", alu_op, ex_rd, ex_valid); end
        clear_fwd();
    endtask

    task automatic test_no_stall_cases();
        set_id(1, 5'd1, 5'd0, 32'd0, 32'd0, 32'd4, 1, 3'd0, 5'd9, 1, 1);
        step();
        set_id(1, 5'd2, 5'd9, 32'd0, 32'd0, 32'd1, 1, 3'd0, 5'd12, 1, 0);
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL imm_no_stall got %0h exp 0", stall_id); end
        id_use_imm = 0;
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL rs2_stall got %0h exp 1", stall_id); end
        id_valid = 0;
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL invalid_no_stall got %0h exp 0", stall_id); end
        set_id(1, 5'd1, 5'd0, 32'd0, 32'd0, 32'd4, 1, 3'd0, 5'd0, 1, 1);
        step();
        set_id(1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 3'd0, 5'd13, 1, 0);
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL x0_load_no_stall got %0h exp 0", stall_id); end
    endtask

    task automatic test_flush();
        set_id(1, 5'd1, 5'd0, 32'd0, 32'd0, 32'd4, 1, 3'd0, 5'd7, 1, 1);
        step();
        set_id(1, 5'd7, 5'd2, 32'd0, 32'd0, 32'd0, 0, 3'd3, 5'd14, 1, 0);
        flush = 1;
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL flush_stall_out got %0h exp 1", stall_id); end
        step();
        flush = 0;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL flush_bubble got %0h/%0h/%0h exp 0/0/0", ex_valid, ex_reg_write, ex_mem_read); end
        checks++; if (ex_rd !== 5'd0 || alu_op !== 3'd0) begin errors++; $display("FAIL flush_no_capture got %0h/%0h exp 0/0", ex_rd, alu_op); end
        set_id(1, 5'd3, 5'd4, 32'd2, 32'd6, 32'd0, 0, 3'd2, 5'd15, 1, 0);
        flush = 1;
        step();
        flush = 0;
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL flush_alone got %0h/%0h exp 0/0", ex_valid, ex_rd); end
    endtask

    task automatic test_use_imm();
        set_id(1, 5'd2, 5'd9, 32'h33, 32'd0, 32'h0F, 1, 3'd4, 5'd8, 1, 0);
        step();
        exm_rd = 5'd9; exm_reg_write = 1; exm_result = 32'hAA;
        #1;
        checks++; if (operand2 !== 32'h0F) begin errors++; $display("FAIL imm_op2 got %0h exp f", operand2); end
        checks++; if (ex_rs2_fwd !== 32'hAA) begin errors++; $display("FAIL imm_rs2_fwd got %0h exp aa", ex_rs2_fwd); end
        checks++; if (alu_op !== 3'd4 || operand1 !== 32'h33) begin errors++; $display("FAIL imm_ctrl got %0h/%0h exp 4/33", alu_op, operand1); end
        clear_fwd();
    endtask

    task automatic test_back_to_back();
        set_id(1, 5'd1, 5'd2, 32'h100, 32'h200, 32'd0, 0, 3'd3, 5'd16, 1, 0);
        step();
        set_id(1, 5'd3, 5'd4, 32'h300, 32'h400, 32'd0, 0, 3'd1, 5'd17, 0, 0);
        #1;
        checks++; if (operand1 !== 32'h100 || alu_op !== 3'd3 || ex_rd !== 5'd16) begin errors++; $display("FAIL b2b_first got %0h/%0h/%0h exp 100/3/10", operand1, alu_op, ex_rd); end
        step();
        id_valid = 0;
        checks++; if (operand2 !== 32'h400 || alu_op !== 3'd1 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL b2b_second got %0h/%0h/%0h exp 400/1/0", operand2, alu_op, ex_reg_write); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL idle_invalid got %0h/%0h exp 0/0", ex_valid, ex_reg_write); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 5'd1, 5'd0, 32'd0, 32'd0, 32'd4, 1, 3'd0, 5'd5, 1, 1);
        step();
        set_id(1, 5'd5, 5'd0, 32'd0, 32'd0, 32'd0, 0, 3'd0, 5'd6, 1, 0);
        rst = 1;
        step();
        rst = 0;
        #1;
        checks++; if (stall_id !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %0h/%0h exp 0/0", stall_id, ex_valid); end
    endtask

    initial begin
        test_reset();
        test_exm_fwd();
        test_x0_guard();
        test_load_use();
        test_no_stall_cases();
        test_flush();
        test_use_imm();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
